// File: rtl/aes128_mode_engine.sv
// AES-128 ECB/CBC/CTR streaming engine around an iterative aes128_encrypt core.
// Define AES_MODE_CTR_WRAP_ERR_EN to make a CTR counter wrap a sticky error.

module aes128_encrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] plain_text_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [127:0] cipher_text_o
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as x^254 in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  t, y;
        logic [15:0] d;
        t = x;
        y = 8'h01;
        for (int k = 0; k < 7; k++) begin
            t = gmul(t, t);
            y = gmul(y, t);
        end
        d = {y, y};
        return y ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ rk;
    endfunction

    logic         busy_q, done_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;
    logic [127:0] st_q, rk_q, nk;

    always_comb nk = next_key(rk_q, rcon_q);

    // One round per cycle: start -> done_o is 10 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            round_q <= '0;
            rcon_q  <= '0;
            st_q    <= '0;
            rk_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                st_q    <= plain_text_i ^ key_i;
                rk_q    <= key_i;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                st_q    <= aes_round(st_q, nk, round_q == 4'd10);
                rk_q    <= nk;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                if (round_q == 4'd10) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_o       = !busy_q;
        done_o        = done_q;
        cipher_text_o = st_q;
    end
endmodule

module aes128_mode_engine #(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic [1:0]   mode_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         busy_o,
    output logic         cfg_ok_o,
    output logic         err_o
);
    localparam int unsigned PtrW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);
    localparam logic [1:0]  ModeCbc = 2'b01;
    localparam logic [1:0]  ModeCtr = 2'b10;

    typedef enum logic [1:0] {StIdle, StWaitIn, StRun, StDrainChk} state_e;

    state_e            state_q, state_d;
    logic [127:0]      key_q, chain_q, ctr_q, p_q, ctr_next, core_pt, core_ct, result;
    logic [1:0]        mode_q;
    logic              start_q, cfg_ok_q, core_ready, core_done;
    logic              busy, cfg_take, in_fire, pop, wrap_err;
    logic [127:0]      mem [OUT_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;

    aes128_encrypt u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_q),
        .key_i         (key_q),
        .plain_text_i  (core_pt),
        .ready_o       (core_ready),
        .done_o        (core_done),
        .cipher_text_o (core_ct)
    );

    always_comb begin
        busy        = (state_q == StRun) || (count_q != '0);
        cfg_take    = cfg_start_i && !busy;
        in_ready_o  = (state_q == StWaitIn) && core_ready && (count_q < CntW'(OUT_DEPTH));
        in_fire     = in_valid_i && in_ready_o;
        out_valid_o = (count_q != '0);
        pop         = out_valid_o && out_ready_i;
        out_data_o  = mem[rptr_q];
        busy_o      = busy;
        cfg_ok_o    = cfg_ok_q;
        ctr_next    = ctr_q;
        ctr_next[CTR_WIDTH-1:0] = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
        unique case (mode_q)
            ModeCbc: core_pt = p_q ^ chain_q;
            ModeCtr: core_pt = ctr_q;
            default: core_pt = p_q;
        endcase
        result = (mode_q == ModeCtr) ? (p_q ^ core_ct) : core_ct;
`ifdef AES_MODE_CTR_WRAP_ERR_EN
        wrap_err = (mode_q == ModeCtr) && (ctr_next[CTR_WIDTH-1:0] == '0);
        err_o    = (state_q == StDrainChk);
`else
        wrap_err = 1'b0;
        err_o    = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cfg_take) state_d = StWaitIn;
            StWaitIn:   if (in_fire) state_d = StRun;
            StRun:      if (core_done) state_d = wrap_err ? StDrainChk : StWaitIn;
            StDrainChk: if (cfg_take) state_d = StWaitIn;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            key_q    <= '0;
            mode_q   <= '0;
            chain_q  <= '0;
            ctr_q    <= '0;
            p_q      <= '0;
            start_q  <= 1'b0;
            cfg_ok_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            start_q <= in_fire;
            if (cfg_take) begin
                cfg_ok_q <= 1'b1;
                key_q    <= key_i;
                mode_q   <= mode_i;
                if (mode_i == ModeCbc) chain_q <= iv_i;
                if (mode_i == ModeCtr) ctr_q <= iv_i;
            end
            if (in_fire) p_q <= in_data_i;
            // Room was reserved at the input handshake, so this write can never overflow.
            if (core_done) begin
                if (mode_q == ModeCbc) chain_q <= core_ct;
                if (mode_q == ModeCtr) ctr_q <= ctr_next;
                mem[wptr_q] <= result;
                wptr_q <= (wptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) rptr_q <= (rptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            if (core_done && !pop) count_q <= count_q + 1'b1;
            else if (!core_done && pop) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: doc/aes128_mode_engine.md
Name: aes128_mode_engine

Overview:
Streaming AES-128 block-mode engine wrapping one aes128_encrypt core. Adds ECB, CBC-encrypt and CTR modes, a valid/ready block stream in and out, and a parametrised output buffer. Sits between the DMA/bus front-end and the existing AES core, which it instantiates unmodified.

Parameters:
OUT_DEPTH, 2, output buffer entries (power of 2, ≥1); also bounds blocks in flight plus buffered.
CTR_WIDTH, 32, low bits of the counter block that increment in CTR mode (1..128).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_start_i  in  1  one-cycle pulse; latches key_i, iv_i, mode_i
key_i  in  128  AES-128 key
iv_i  in  128  CBC IV / CTR initial counter block
mode_i  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved (treated as ECB)
in_valid_i  in  1  input block valid
in_ready_o  out  1  input block accepted when in_valid_i && in_ready_o
in_data_i  in  128  plaintext block
out_valid_o  out  1  output block valid
out_ready_i  in  1  output block consumed when out_valid_o && out_ready_i
out_data_o  out  128  ciphertext block
busy_o  out  1  block in core or buffer non-empty
cfg_ok_o  out  1  engine configured since reset
err_o  out  1  CTR wrap error (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; FSM IDLE; buffer empty; key, chain and counter registers 0.
- Core contract: pulse core start_i only when core ready_o=1. Core asserts done_o for one cycle with cipher_text_o valid.
- FSM states: IDLE (unconfigured), WAIT_IN, RUN, DRAIN_CHK.
  - IDLE→WAIT_IN on cfg_start_i.
  - WAIT_IN→RUN on input handshake; core start pulses the next cycle.
  - RUN→WAIT_IN on core done_o.
- cfg_start_i is honoured only when busy_o=0; otherwise it is ignored with no state change. Honouring it sets cfg_ok_o=1, latches key and mode, loads chain=iv_i (CBC) or ctr=iv_i (CTR).
- in_ready_o = (state==WAIT_IN) && core ready_o && (buffer count < OUT_DEPTH). One block in flight max.
- Core input and result by mode:
  - ECB: core input P; result C=E(P).
  - CBC: core input P^chain; result C=E(P^chain); chain<=C on done_o.
  - CTR: core input ctr; result C=P^E(ctr), with P registered at handshake. On done_o, ctr[CTR_WIDTH-1:0] increments mod 2^CTR_WIDTH; upper bits unchanged.
- Result is written into the buffer on the done_o cycle. out_valid_o rises the next cycle.
- Latency input handshake→out_valid_o = core latency + 2 cycles with an empty buffer.
- Buffer is a FIFO in order. Simultaneous write and read when full is legal; in-flight accounting prevents overflow, so no drop is ever allowed.
- out_data_o is stable while out_valid_o && !out_ready_i.
- Async reset mid-block: everything clears, including buffered data. Any core result arriving after reset is discarded because the core is reset by the same rst_n.

Optional Feature:
Macro AES_MODE_CTR_WRAP_ERR_EN.
- Defined: in CTR mode, if the incremented low CTR_WIDTH bits wrap to 0, err_o sets sticky, and in_ready_o is forced 0 until the next honoured cfg_start_i, which clears err_o. Blocks already buffered still drain.
- Undefined: wrap is silent, err_o tied 0.

Test Plan:
- ECB, key 2b7e151628aed2a6abf7158809cf4f3c, P 6bc1bee22e409f96e93d7e117393172a → out 3ad77bb40d7a3660a89ecaf32466ef97; busy_o falls after pop.
- CBC, same key, IV 000102030405060708090a0b0c0d0e0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 back-to-back → 7649abac8119b246cee98e9b12e9197d then 5086cb9b507219ee95db113a917678b2, in order.
- CTR, same key, IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, P1 6bc1bee22e409f96e93d7e117393172a → 874d6191b620e3261bef6864990db6ce; internal ctr becomes ...fcfdff00.
- Backpressure: out_ready_i=0, push OUT_DEPTH+1 blocks → exactly OUT_DEPTH accepted and in_ready_o=0; release out_ready_i → all outputs in order, no loss, data stable while stalled.
- CTR wrap, IV low 32 bits ffffffff → next counter has low 32 bits 00000000 and upper 96 bits unchanged. With macro defined: err_o=1 and in_ready_o=0 until cfg_start_i.
- Assert cfg_start_i while busy → ignored (mode and chain unchanged). Assert rst_n=0 during RUN → all outputs 0, buffer empty, cfg_ok_o=0.
